fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter sharing one async-FIFO write port between
//            NUM_REQ valid/ready requesters. A grant lasts for a burst of up
//            to MAX_BURST beats. Writes are gated by fifo_full.
//            Optional statistics counters are enabled with the macro
//            FIFO_WR_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int MAX_BURST       = 4,
    localparam int c_GRANT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               wr_clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               fifo_full,
    output logic                               fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0]         fifo_din,
    output logic                               grant_valid,
    output logic [c_GRANT_W-1:0]               grant_id
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    input  logic                               stats_clr,
    output logic [NUM_REQ*16-1:0]              beat_count,
    output logic [15:0]                        stall_count
`endif
);

    localparam int         c_CNT_W  = $clog2(MAX_BURST) + 1;
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_BURST  = 1'b1;

    logic [0:0]                 r_state;
    logic [c_GRANT_W-1:0]       r_rr_ptr;
    logic [c_GRANT_W-1:0]       r_grant_id;
    logic [c_CNT_W-1:0]         r_beat_cnt;

    logic                       w_burst;
    logic                       w_sel_valid;
    logic [FIFO_DATA_WIDTH-1:0] w_sel_data;
    logic                       w_xfer;
    logic                       w_last_beat;
    logic                       w_any_valid;
    logic [c_GRANT_W-1:0]       w_next_id;
    logic [c_GRANT_W-1:0]       w_ptr_after;

    // Reset forces the port idle in the same cycle so no beat escapes mid-reset.
    assign w_burst     = (r_state == c_BURST) && !reset;
    assign w_xfer      = w_burst && w_sel_valid && !fifo_full;
    assign w_last_beat = (r_beat_cnt == c_CNT_W'(MAX_BURST - 1));
    assign w_any_valid = |req_valid;
    assign w_ptr_after = (r_grant_id == c_GRANT_W'(NUM_REQ - 1)) ? '0 : r_grant_id + c_GRANT_W'(1);

    assign fifo_wr_en  = w_xfer;
    assign fifo_din    = w_burst ? w_sel_data : '0;
    assign grant_valid = w_burst;
    assign grant_id    = r_grant_id;

    // Select valid/data of the granted requester and steer ready back to it.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == c_GRANT_W'(i)) begin
                w_sel_valid  = req_valid[i];
                w_sel_data   = req_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
                req_ready[i] = w_xfer;
            end
        end
    end

    // Round-robin search starting at rr_ptr; scanning downwards leaves the closest hit.
    always_comb begin
        w_next_id = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                w_next_id = c_GRANT_W'(idx);
            end
        end
    end

    // Arbitration FSM: one IDLE cycle to pick a requester, then a bounded burst.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id <= w_next_id;
                        r_beat_cnt <= '0;
                        r_state    <= c_BURST;
                    end
                end
                c_BURST: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                    end
                    // A requester dropping valid ends its burst, even with zero beats.
                    if ((w_xfer && w_last_beat) || !w_sel_valid) begin
                        r_state  <= c_IDLE;
                        r_rr_ptr <= w_ptr_after;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic        w_stall;
    logic [15:0] r_stall_count;

    assign w_stall     = w_burst && w_sel_valid && fifo_full;
    assign stall_count = r_stall_count;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_beat_cnt
        logic [15:0] r_cnt;

        // Saturating count of beats accepted from this requester.
        always_ff @(posedge wr_clk) begin
            if (reset || stats_clr) begin
                r_cnt <= '0;
            end else if (req_ready[gi] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign beat_count[gi*16 +: 16] = r_cnt;
    end

    // Saturating count of cycles the granted requester was blocked by fifo_full.
    always_ff @(posedge wr_clk) begin
        if (reset || stats_clr) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed self-checking bench for fifo_wr_arbiter
//            (NUM_REQ=4, FIFO_DATA_WIDTH=8, MAX_BURST=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;

    logic                   wr_clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*W-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [W-1:0]           fifo_din;
    logic                   grant_valid;
    logic [1:0]             grant_id;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic                   stats_clr;
    logic [NUM_REQ*16-1:0]  beat_count;
    logic [15:0]            stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int writes;

    fifo_wr_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .FIFO_DATA_WIDTH (W),
        .MAX_BURST       (MAX_BURST)
    ) dut (
        .wr_clk      (wr_clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .beat_count  (beat_count),
        .stall_count (stall_count)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge wr_clk);
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] val);
        req_data[idx*W +: W] = val;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h13121110;
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif

        // ---- 1: reset with every requester valid ----
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t1 rst wr_en", 32'(fifo_wr_en), 0);
            check("t1 rst ready", 32'(req_ready), 0);
            check("t1 rst gvalid", 32'(grant_valid), 0);
            check("t1 rst din", 32'(fifo_din), 0);
            tick();
        end
        reset = 1'b0;
        sample();
        check("t1 idle gvalid", 32'(grant_valid), 0);
        check("t1 idle wr_en", 32'(fifo_wr_en), 0);
        tick();
        sample();
        check("t1 grant valid", 32'(grant_valid), 1);
        check("t1 grant id", 32'(grant_id), 0);
        check("t1 first wr_en", 32'(fifo_wr_en), 1);
        check("t1 first din", 32'(fifo_din), 32'h10);

        // ---- 2: single requester 2, three beats then drop valid ----
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 8'hA1);
        sample();
        check("t2 idle wr_en", 32'(fifo_wr_en), 0);
        check("t2 idle gvalid", 32'(grant_valid), 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_data(2, 8'(8'hA1 + b));
            sample();
            check("t2 beat wr_en", 32'(fifo_wr_en), 1);
            check("t2 beat din", 32'(fifo_din), 32'(8'hA1 + b));
            check("t2 beat gid", 32'(grant_id), 2);
            check("t2 beat ready", 32'(req_ready), 32'h4);
            tick();
        end
        req_valid = '0;
        sample();
        check("t2 drop wr_en", 32'(fifo_wr_en), 0);
        check("t2 drop ready", 32'(req_ready), 0);
        tick();
        sample();
        check("t2 back idle", 32'(grant_valid), 0);
        req_valid = 4'b1001;
        tick();
        sample();
        check("t2 rr ptr at 3", 32'(grant_id), 3);
        check("t2 rr wr_en", 32'(fifo_wr_en), 1);

        // ---- 3: all requesters continuously valid ----
        do_reset();
        req_valid = 4'hF;
        req_data  = 32'h13121110;
        writes    = 0;
        sample();
        check("t3 idle", 32'(grant_valid), 0);
        tick();
        for (int n = 1; n <= 21; n++) begin
            int p;
            int g;
            sample();
            p = (n - 1) % 5;
            g = ((n - 1) / 5) % 4;
            if (p < 4) begin
                check("t3 wr_en", 32'(fifo_wr_en), 1);
                check("t3 gid", 32'(grant_id), 32'(g));
                check("t3 din", 32'(fifo_din), 32'(16 + g));
            end else begin
                check("t3 gap wr_en", 32'(fifo_wr_en), 0);
            end
            if (n <= 20 && fifo_wr_en) writes++;
`ifdef FIFO_WR_ARBITER_STATS_EN
            if (n == 21) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    check("t6 beat_count", 32'(beat_count[r*16 +: 16]), 4);
                end
                check("t6 stall_count", 32'(stall_count), 0);
                stats_clr = 1'b1;
            end
`endif
            tick();
        end
        check("t3 writes in 20", 32'(writes), 16);
`ifdef FIFO_WR_ARBITER_STATS_EN
        stats_clr = 1'b0;
        sample();
        check("t6 clr beats", 32'(beat_count[63:32]) | 32'(beat_count[31:0]), 0);
        check("t6 clr stall", 32'(stall_count), 0);
`endif

        // ---- 4: fifo_full stalls requester 1 after two beats ----
        do_reset();
        req_valid = 4'b0110;
        set_data(1, 8'h41);
        set_data(2, 8'h42);
        sample();
        check("t4 idle", 32'(grant_valid), 0);
        tick();
        for (int b = 0; b < 2; b++) begin
            sample();
            check("t4 pre wr_en", 32'(fifo_wr_en), 1);
            check("t4 pre gid", 32'(grant_id), 1);
            check("t4 pre ready", 32'(req_ready), 32'h2);
            tick();
        end
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t4 full wr_en", 32'(fifo_wr_en), 0);
            check("t4 full ready", 32'(req_ready), 0);
            check("t4 full gvalid", 32'(grant_valid), 1);
            check("t4 full gid", 32'(grant_id), 1);
            tick();
        end
        fifo_full = 1'b0;
        for (int b = 0; b < 2; b++) begin
            sample();
            check("t4 post wr_en", 32'(fifo_wr_en), 1);
            check("t4 post gid", 32'(grant_id), 1);
            tick();
        end
        sample();
        check("t4 end idle", 32'(grant_valid), 0);
`ifdef FIFO_WR_ARBITER_STATS_EN
        check("t4 stall_count", 32'(stall_count), 3);
        check("t4 beat_count1", 32'(beat_count[31:16]), 4);
`endif
        tick();
        sample();
        check("t4 rotate gid", 32'(grant_id), 2);
        check("t4 rotate din", 32'(fifo_din), 32'h42);

        // ---- 5: reset during beat 2 of requester 3 ----
        do_reset();
        req_valid = 4'b1000;
        set_data(3, 8'hC1);
        set_data(0, 8'h50);
        sample();
        check("t5 idle", 32'(grant_valid), 0);
        tick();
        sample();
        check("t5 beat1 wr_en", 32'(fifo_wr_en), 1);
        check("t5 beat1 gid", 32'(grant_id), 3);
        check("t5 beat1 din", 32'(fifo_din), 32'hC1);
        tick();
        set_data(3, 8'hC2);
        reset = 1'b1;
        sample();
        check("t5 rst wr_en", 32'(fifo_wr_en), 0);
        check("t5 rst ready", 32'(req_ready), 0);
        tick();
        reset     = 1'b0;
        req_valid = 4'b1011;
        sample();
        check("t5 post idle", 32'(grant_valid), 0);
        check("t5 post wr_en", 32'(fifo_wr_en), 0);
        tick();
        sample();
        check("t5 regrant gid", 32'(grant_id), 0);
        check("t5 regrant din", 32'(fifo_din), 32'h50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
